// File: rtl/cdec_shell_pkg.sv
// Shared types and default timing constants for the CDEC front-panel shell.
package cdec_shell_pkg;

   typedef enum logic [1:0] {
      ST_PROG = 2'd0,
      ST_ARM  = 2'd1,
      ST_RUN  = 2'd2,
      ST_HALT = 2'd3
   } seq_state_t;

   localparam int DEF_DB_CYCLES  = 50000;
   localparam int DEF_ARM_CYCLES = 2;

endpackage

// File: rtl/prog_run_controller_if.sv
// Front-panel inputs and CPU/program-memory controls of the mode sequencer.
interface prog_run_controller_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
);
   logic              mode_sw;
   logic              p_clock_btn;
   logic              step_btn;
   logic              free_run;
   logic [DATA_W-1:0] io_in;
   logic              endseq;

   logic              prog_we;
   logic [ADDR_W-1:0] prog_addr;
   logic [DATA_W-1:0] prog_data;
   logic              cpu_en;
   logic              cpu_reset_N;
   logic [1:0]        seq_state;
   logic              halted;

   modport master (
      output mode_sw, p_clock_btn, step_btn, free_run, io_in, endseq,
      input  prog_we, prog_addr, prog_data, cpu_en, cpu_reset_N, seq_state, halted
   );

   modport slave (
      input  mode_sw, p_clock_btn, step_btn, free_run, io_in, endseq,
      output prog_we, prog_addr, prog_data, cpu_en, cpu_reset_N, seq_state, halted
   );
endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer.
// chg_o pulses for one cycle in the same cycle level_o takes its new value.
module btn_debounce #(
   parameter int   DB_CYCLES = 4,
   parameter logic RST_LVL   = 1'b1
) (
   input  logic clock,
   input  logic reset_N,
   input  logic raw_i,
   output logic level_o,
   output logic chg_o
);
   localparam int            CW     = $clog2(DB_CYCLES);
   localparam logic [CW-1:0] RELOAD = CW'(DB_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic          chg_q;
   logic [CW-1:0] cnt_q, cnt_d;

   // Down-counter runs only while the synced input disagrees with the held level.
   always_comb begin
      level_d = level_q;
      cnt_d   = RELOAD;
      if (sync2_q != level_q) begin
         if (cnt_q == '0) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q - CW'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset_N) begin
      if (!reset_N) begin
         sync1_q <= RST_LVL;
         sync2_q <= RST_LVL;
         level_q <= RST_LVL;
         cnt_q   <= RELOAD;
         chg_q   <= 1'b0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         chg_q   <= (level_d != level_q);
      end
   end

   assign level_o = level_q;
   assign chg_o   = chg_q;
endmodule

// File: rtl/prog_run_controller.sv
// Mode sequencer between the DE0 front panel and the CDEC CPU core:
// programs memory from the switches, then arms, runs and halts the core.
//
//  state | meaning
//  PROG  | core held in reset, p_clock presses write io_in at prog_addr
//  ARM   | core reset held for ARM_CYCLES, address cleared
//  RUN   | core released, cpu_en free-running or one cycle per step press
//  HALT  | endseq seen, core frozen but visible until mode_sw returns to 0
module prog_run_controller
   import cdec_shell_pkg::*;
#(
   parameter int ADDR_W     = 4,
   parameter int DATA_W     = 8,
   parameter int DB_CYCLES  = DEF_DB_CYCLES,
   parameter int ARM_CYCLES = DEF_ARM_CYCLES
) (
   input logic             clock,
   input logic             reset_N,
   prog_run_controller_if.slave bus
);
   localparam int             ACW        = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
   localparam logic [ACW-1:0] ARM_RELOAD = ACW'(ARM_CYCLES - 1);

   logic pclk_lvl, pclk_chg;
   logic step_lvl, step_chg;
   logic mode_lvl, mode_chg;
   logic p_press, step_press, mode_rise, mode_fall;

   seq_state_t        state_q, state_d;
   logic              prog_we_q, prog_we_d;
   logic [ADDR_W-1:0] prog_addr_q, prog_addr_d;
   logic [DATA_W-1:0] prog_data_q, prog_data_d;
   logic              cpu_en_q, cpu_en_d;
   logic              cpu_reset_n_q, cpu_reset_n_d;
   logic [ACW-1:0]    arm_cnt_q, arm_cnt_d;
   logic              cpu_en_w;

   btn_debounce #(.DB_CYCLES(DB_CYCLES), .RST_LVL(1'b1)) u_db_pclk (
      .clock   (clock),
      .reset_N (reset_N),
      .raw_i   (bus.p_clock_btn),
      .level_o (pclk_lvl),
      .chg_o   (pclk_chg)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES), .RST_LVL(1'b1)) u_db_step (
      .clock   (clock),
      .reset_N (reset_N),
      .raw_i   (bus.step_btn),
      .level_o (step_lvl),
      .chg_o   (step_chg)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES), .RST_LVL(1'b0)) u_db_mode (
      .clock   (clock),
      .reset_N (reset_N),
      .raw_i   (bus.mode_sw),
      .level_o (mode_lvl),
      .chg_o   (mode_chg)
   );

   assign p_press    = pclk_chg & ~pclk_lvl;
   assign step_press = step_chg & ~step_lvl;
   assign mode_rise  = mode_chg &  mode_lvl;
   assign mode_fall  = mode_chg & ~mode_lvl;

   // A falling mode switch must stop the core in the very cycle it is seen.
   assign cpu_en_w = cpu_en_q & ~mode_fall;

   always_ff @(posedge clock or negedge reset_N) begin
      if (!reset_N) begin
         state_q <= ST_PROG;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_PROG: if (mode_rise) state_d = ST_ARM;
         ST_ARM: begin
            if (mode_fall)              state_d = ST_PROG;
            else if (arm_cnt_q == '0)   state_d = ST_RUN;
         end
         ST_RUN: begin
            if (mode_fall)              state_d = ST_PROG;
            else if (bus.endseq && cpu_en_w) state_d = ST_HALT;
         end
         ST_HALT: if (mode_fall) state_d = ST_PROG;
         default: state_d = ST_PROG;
      endcase
   end

   always_comb begin
      prog_we_d   = (state_q == ST_PROG) && p_press && !mode_rise;
      prog_data_d = prog_we_d ? bus.io_in : prog_data_q;

      // Address is zero everywhere except while staying in PROG.
      if ((state_q != ST_PROG) || (state_d != ST_PROG)) begin
         prog_addr_d = '0;
      end else if (prog_we_q) begin
         prog_addr_d = prog_addr_q + ADDR_W'(1);
      end else begin
         prog_addr_d = prog_addr_q;
      end

      cpu_en_d      = (state_q == ST_RUN) && (state_d == ST_RUN) && (bus.free_run || step_press);
      cpu_reset_n_d = (state_d == ST_RUN) || (state_d == ST_HALT);
      arm_cnt_d     = (state_q == ST_ARM) ? (arm_cnt_q - ACW'(1)) : ARM_RELOAD;
   end

   always_ff @(posedge clock or negedge reset_N) begin
      if (!reset_N) begin
         prog_we_q     <= 1'b0;
         prog_addr_q   <= '0;
         prog_data_q   <= '0;
         cpu_en_q      <= 1'b0;
         cpu_reset_n_q <= 1'b0;
         arm_cnt_q     <= ARM_RELOAD;
      end else begin
         prog_we_q     <= prog_we_d;
         prog_addr_q   <= prog_addr_d;
         prog_data_q   <= prog_data_d;
         cpu_en_q      <= cpu_en_d;
         cpu_reset_n_q <= cpu_reset_n_d;
         arm_cnt_q     <= arm_cnt_d;
      end
   end

   assign bus.prog_we     = prog_we_q;
   assign bus.prog_addr   = prog_addr_q;
   assign bus.prog_data   = prog_data_q;
   assign bus.cpu_en      = cpu_en_w;
   assign bus.cpu_reset_N = cpu_reset_n_q;
   assign bus.seq_state   = state_q;
   assign bus.halted      = (state_q == ST_HALT);
endmodule

// File: tb/tb_prog_run_controller.sv
// Scoreboard bench for prog_run_controller: expected writes and step pulses are
// queued at stimulus time and matched by an independent output monitor.
module tb_prog_run_controller;
   localparam int ADDR_W = 4;
   localparam int DATA_W = 8;
   localparam int DB     = 4;
   localparam int HOLD   = DB + 8;
   localparam int DEPTH  = 1 << ADDR_W;

   logic clock   = 1'b0;
   logic reset_N = 1'b0;
   always #5 clock = ~clock;

   prog_run_controller_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   prog_run_controller #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DB_CYCLES(DB), .ARM_CYCLES(2)
   ) dut (
      .clock   (clock),
      .reset_N (reset_N),
      .bus     (bus)
   );

   typedef struct packed {
      logic              is_step;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } ev_t;

   ev_t  exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   model_addr = 0;
   logic fr_prev = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // cpu_en in a cycle reflects free_run as it was sampled at the preceding edge
   always @(posedge clock) fr_prev <= bus.free_run;

   always @(negedge clock) begin : monitor
      ev_t e;
      if (reset_N) begin
         check("we_outside_prog", 32'(bus.prog_we && (bus.seq_state != 2'd0)), 32'd0);
         check("en_outside_run",  32'(bus.cpu_en  && (bus.seq_state != 2'd2)), 32'd0);
         if (bus.prog_we) begin
            if (exp_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL sb_write: unexpected write addr=%0d data=%0h, nothing expected", bus.prog_addr, bus.prog_data);
            end else begin
               e = exp_q.pop_front();
               check("sb_kind_write", 32'd0, 32'(e.is_step));
               check("sb_addr", 32'(bus.prog_addr), 32'(e.addr));
               check("sb_data", 32'(bus.prog_data), 32'(e.data));
            end
         end
         if (bus.cpu_en && !fr_prev) begin
            if (exp_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL sb_step: unexpected cpu_en pulse, nothing expected (t=%0t)", $time);
            end else begin
               e = exp_q.pop_front();
               check("sb_kind_step", 32'd1, 32'(e.is_step));
            end
         end
      end
   end

   task automatic press_pclk(input logic [DATA_W-1:0] d);
      ev_t e;
      e.is_step = 1'b0;
      e.addr    = ADDR_W'(model_addr);
      e.data    = d;
      exp_q.push_back(e);
      model_addr = (model_addr + 1) % DEPTH;
      bus.io_in = d;
      bus.p_clock_btn = 1'b0;
      cyc(HOLD);
      bus.p_clock_btn = 1'b1;
      cyc(HOLD + $urandom_range(0, 3));
   endtask

   task automatic press_step(input bit expect_pulse);
      ev_t e;
      if (expect_pulse) begin
         e.is_step = 1'b1;
         e.addr    = '0;
         e.data    = '0;
         exp_q.push_back(e);
      end
      bus.step_btn = 1'b0;
      cyc(HOLD);
      bus.step_btn = 1'b1;
      cyc(HOLD + $urandom_range(0, 3));
   endtask

   task automatic wait_state(input logic [1:0] target, input int bound, input string name);
      int i;
      i = 0;
      while ((bus.seq_state != target) && (i < bound)) begin
         cyc(1);
         i++;
      end
      check(name, 32'(bus.seq_state), 32'(target));
   endtask

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1);
   end

   initial begin
      int arm_len;
      logic rst_low;
      bus.mode_sw = 1'b0;
      bus.p_clock_btn = 1'b1;
      bus.step_btn = 1'b1;
      bus.free_run = 1'b0;
      bus.io_in = '0;
      bus.endseq = 1'b0;
      cyc(3);
      reset_N = 1'b1;
      cyc(2);

      // reset state
      check("rst_state",   32'(bus.seq_state),   32'd0);
      check("rst_cpu_rst", 32'(bus.cpu_reset_N), 32'd0);
      check("rst_addr",    32'(bus.prog_addr),   32'd0);
      check("rst_data",    32'(bus.prog_data),   32'd0);
      check("rst_we",      32'(bus.prog_we),     32'd0);
      check("rst_en",      32'(bus.cpu_en),      32'd0);
      check("rst_halted",  32'(bus.halted),      32'd0);

      // two directed writes
      press_pclk(8'hA5);
      press_pclk(8'h3C);
      check("addr_after_two", 32'(bus.prog_addr), 32'(model_addr));

      // fill to wrap, then a full randomized pass from address 0
      for (int i = 0; i < DEPTH - 2; i++) press_pclk(DATA_W'($urandom));
      check("addr_wrapped", 32'(bus.prog_addr), 32'd0);
      for (int i = 0; i < DEPTH; i++) press_pclk(DATA_W'($urandom));
      check("addr_wrapped_again", 32'(bus.prog_addr), 32'd0);
      check("sb_drained_prog", 32'(exp_q.size()), 32'd0);

      // short bounces never reach the debounced level
      for (int i = 0; i < 3; i++) begin
         bus.p_clock_btn = 1'b0;
         cyc((i == 0) ? 3 : $urandom_range(1, 3));
         bus.p_clock_btn = 1'b1;
         cyc(HOLD);
      end
      check("addr_after_bounce", 32'(bus.prog_addr), 32'(model_addr));

      // leave a non-zero address so ARM clearing is observable
      for (int i = 0; i < int'($urandom_range(2, 5)); i++) press_pclk(DATA_W'($urandom));
      check("addr_before_arm", 32'(bus.prog_addr), 32'(model_addr));

      // ARM then RUN in single-step mode
      bus.free_run = 1'b0;
      bus.mode_sw = 1'b1;
      wait_state(2'd1, 40, "enter_arm");
      arm_len = 0;
      rst_low = 1'b1;
      for (int i = 0; (i < 10) && (bus.seq_state == 2'd1); i++) begin
         arm_len++;
         if (bus.cpu_reset_N !== 1'b0) rst_low = 1'b0;
         cyc(1);
      end
      model_addr = 0;
      check("arm_len",       32'(arm_len),         32'd2);
      check("arm_rst_low",   32'(rst_low),         32'd1);
      check("run_state",     32'(bus.seq_state),   32'd2);
      check("run_cpu_rst",   32'(bus.cpu_reset_N), 32'd1);
      check("run_addr_zero", 32'(bus.prog_addr),   32'd0);

      // p_clock is ignored in RUN; steps each give one cpu_en cycle
      bus.io_in = DATA_W'($urandom);
      bus.p_clock_btn = 1'b0;
      cyc(HOLD);
      bus.p_clock_btn = 1'b1;
      cyc(HOLD);
      for (int i = 0; i < 3; i++) press_step(1'b1);
      check("sb_drained_steps", 32'(exp_q.size()), 32'd0);

      // free-run then endseq halts
      bus.free_run = 1'b1;
      cyc(2 + $urandom_range(0, 4));
      check("freerun_en", 32'(bus.cpu_en), 32'd1);
      bus.endseq = 1'b1;
      cyc(1);
      bus.endseq = 1'b0;
      bus.free_run = 1'b0;
      check("halt_en_low",  32'(bus.cpu_en),      32'd0);
      check("halt_state",   32'(bus.seq_state),   32'd3);
      check("halt_flag",    32'(bus.halted),      32'd1);
      check("halt_cpu_rst", 32'(bus.cpu_reset_N), 32'd1);
      for (int i = 0; i < 2; i++) press_step(1'b0);
      check("halt_sticky", 32'(bus.seq_state), 32'd3);

      // mode fall together with a p_clock press: back to PROG, press dropped
      bus.io_in = DATA_W'($urandom);
      bus.mode_sw = 1'b0;
      bus.p_clock_btn = 1'b0;
      cyc(HOLD);
      bus.p_clock_btn = 1'b1;
      cyc(HOLD);
      check("fall_state",   32'(bus.seq_state),   32'd0);
      check("fall_addr",    32'(bus.prog_addr),   32'd0);
      check("fall_cpu_rst", 32'(bus.cpu_reset_N), 32'd0);
      check("fall_halted",  32'(bus.halted),      32'd0);
      press_pclk(DATA_W'($urandom));
      check("sb_drained_fall", 32'(exp_q.size()), 32'd0);

      // asynchronous reset in the middle of RUN
      model_addr = 0;
      bus.free_run = 1'b1;
      bus.mode_sw = 1'b1;
      wait_state(2'd2, 40, "rerun_state");
      cyc(3);
      check("rerun_en", 32'(bus.cpu_en), 32'd1);
      @(negedge clock);
      #2;
      reset_N = 1'b0;
      #1;
      check("arst_state",   32'(bus.seq_state),   32'd0);
      check("arst_en",      32'(bus.cpu_en),      32'd0);
      check("arst_cpu_rst", 32'(bus.cpu_reset_N), 32'd0);
      check("arst_addr",    32'(bus.prog_addr),   32'd0);
      check("arst_we",      32'(bus.prog_we),     32'd0);
      check("arst_halted",  32'(bus.halted),      32'd0);
      bus.mode_sw = 1'b0;
      bus.free_run = 1'b0;
      cyc(3);
      reset_N = 1'b1;
      cyc(2 * HOLD);
      check("post_rst_state", 32'(bus.seq_state), 32'd0);
      check("sb_drained_end", 32'(exp_q.size()),  32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
